// File: rtl/wb_queue_pkg.sv
// Shared types and helpers for the write-booster address queue and its CAM matcher.
package wb_queue_pkg;

    localparam int DEF_DATA_SIZE    = 40;
    localparam int DEF_QUEUE_LENGTH = 8;

    // Index width that never collapses to zero bits, even for very small queues.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [DEF_DATA_SIZE-1:0]                  addr_t;
    typedef logic [idx_width(DEF_QUEUE_LENGTH)-1:0]    qidx_t;
    typedef logic [$clog2(DEF_QUEUE_LENGTH):0]         qcnt_t;

endpackage

// File: rtl/wb_addr_cam_match.sv
// Compares one key against every queue entry and returns the oldest matching slot,
// scanning from head toward tail with wrap.
module wb_addr_cam_match
    import wb_queue_pkg::*;
#(
    parameter int DATA_SIZE    = 40,
    parameter int QUEUE_LENGTH = 8
) (
    input  logic [QUEUE_LENGTH*DATA_SIZE-1:0]        entries,
    input  logic [QUEUE_LENGTH-1:0]                  entry_valid,
    input  logic [idx_width(QUEUE_LENGTH)-1:0]       head,
    input  logic [DATA_SIZE-1:0]                     key,
    input  logic                                     key_valid,
    output logic                                     match_hit,
    output logic [idx_width(QUEUE_LENGTH)-1:0]       match_index
);

    localparam int IDX_W = idx_width(QUEUE_LENGTH);

    logic [QUEUE_LENGTH-1:0] match_vec;

    generate
        for (genvar gi = 0; gi < QUEUE_LENGTH; gi++) begin : g_cmp
            assign match_vec[gi] = key_valid && entry_valid[gi] &&
                                   (entries[gi*DATA_SIZE +: DATA_SIZE] == key);
        end
    endgenerate

    // Walk offsets from youngest to oldest so the last hit written is the oldest one.
    always_comb begin
        logic [IDX_W-1:0] slot;
        slot        = '0;
        match_hit   = 1'b0;
        match_index = '0;
        for (int j = QUEUE_LENGTH - 1; j >= 0; j--) begin
            slot = head + IDX_W'(j);
            if (match_vec[slot]) begin
                match_hit   = 1'b1;
                match_index = slot;
            end
        end
    end

endmodule

// File: rtl/wb_addr_queue.sv
// Write-booster address FIFO with parallel CAM lookups and an almost_full threshold.
// Optional duplicate absorption on push is enabled by defining WB_ADDR_QUEUE_COALESCE_EN.
module wb_addr_queue
    import wb_queue_pkg::*;
#(
    parameter int DATA_SIZE     = 40,
    parameter int QUEUE_LENGTH  = 8,
    parameter int REGISTER_SIZE = 32,
    parameter int LOOKUP_PORTS  = 2
) (
    input  logic                                                 clock,
    input  logic                                                 reset_n,
    input  logic [REGISTER_SIZE-1:0]                             higher_threshold,
    input  logic [DATA_SIZE-1:0]                                 push_data,
    input  logic                                                 push_valid,
    output logic                                                 push_ready,
    output logic [DATA_SIZE-1:0]                                 pop_data,
    output logic                                                 pop_valid,
    input  logic                                                 pop_ready,
    output logic [$clog2(QUEUE_LENGTH):0]                        count,
    output logic                                                 empty,
    output logic                                                 full,
    output logic                                                 almost_full,
    input  logic [LOOKUP_PORTS-1:0]                              lookup_valid,
    input  logic [LOOKUP_PORTS*DATA_SIZE-1:0]                    lookup_addr,
    output logic [LOOKUP_PORTS-1:0]                              lookup_hit,
    output logic [LOOKUP_PORTS*idx_width(QUEUE_LENGTH)-1:0]      lookup_index,
    output logic                                                 coalesced
);

    localparam int IDX_W = idx_width(QUEUE_LENGTH);
    localparam int CNT_W = $clog2(QUEUE_LENGTH) + 1;

    logic [DATA_SIZE-1:0]              ram [QUEUE_LENGTH];
    logic [QUEUE_LENGTH-1:0]           valid_reg;
    logic [IDX_W-1:0]                  head_reg;
    logic [IDX_W-1:0]                  tail_reg;
    logic [CNT_W-1:0]                  count_reg;
    logic [CNT_W-1:0]                  count_next;
    logic                              full_reg;
    logic                              empty_reg;
    logic [QUEUE_LENGTH*DATA_SIZE-1:0] entries_flat;
    logic                              push_fire;
    logic                              pop_fire;
    logic                              do_write;
    logic                              dup_hit;

    generate
        for (genvar gi = 0; gi < QUEUE_LENGTH; gi++) begin : g_flat
            assign entries_flat[gi*DATA_SIZE +: DATA_SIZE] = ram[gi];
        end

        for (genvar gi = 0; gi < LOOKUP_PORTS; gi++) begin : g_lookup
            wb_addr_cam_match #(
                .DATA_SIZE    (DATA_SIZE),
                .QUEUE_LENGTH (QUEUE_LENGTH)
            ) u_cam (
                .entries     (entries_flat),
                .entry_valid (valid_reg),
                .head        (head_reg),
                .key         (lookup_addr[gi*DATA_SIZE +: DATA_SIZE]),
                .key_valid   (lookup_valid[gi]),
                .match_hit   (lookup_hit[gi]),
                .match_index (lookup_index[gi*IDX_W +: IDX_W])
            );
        end
    endgenerate

`ifdef WB_ADDR_QUEUE_COALESCE_EN
    logic [IDX_W-1:0] dup_index;

    wb_addr_cam_match #(
        .DATA_SIZE    (DATA_SIZE),
        .QUEUE_LENGTH (QUEUE_LENGTH)
    ) u_coalesce_cam (
        .entries     (entries_flat),
        .entry_valid (valid_reg),
        .head        (head_reg),
        .key         (push_data),
        .key_valid   (push_valid),
        .match_hit   (dup_hit),
        .match_index (dup_index)
    );

    // A duplicate is absorbed even when the queue is full.
    assign push_ready = !full_reg || dup_hit;
    assign coalesced  = push_fire && dup_hit && reset_n;
`else
    assign dup_hit    = 1'b0;
    assign push_ready = !full_reg;
    assign coalesced  = 1'b0;
`endif

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;
    assign do_write  = push_fire && !dup_hit;

    always_comb begin
        count_next = count_reg;
        case ({do_write, pop_fire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_write && reset_n) begin
            ram[tail_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            if (pop_fire) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + IDX_W'(1);
            end
            if (do_write) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + IDX_W'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(QUEUE_LENGTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign count       = count_reg;
    assign empty       = empty_reg;
    assign full        = full_reg;
    assign pop_valid   = !empty_reg;
    assign pop_data    = ram[head_reg];
    assign almost_full = (REGISTER_SIZE'(count_reg) >= higher_threshold);

endmodule

// File: tb/tb_wb_addr_queue.sv
// Directed self-checking bench for wb_addr_queue (default parameters).
module tb_wb_addr_queue;

    localparam int DW = 40;
    localparam int QL = 8;
    localparam int RW = 32;
    localparam int LP = 2;
    localparam int IW = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [RW-1:0]     higher_threshold;
    logic [DW-1:0]     push_data;
    logic              push_valid;
    logic              push_ready;
    logic [DW-1:0]     pop_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [3:0]        count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [LP-1:0]     lookup_valid;
    logic [LP*DW-1:0]  lookup_addr;
    logic [LP-1:0]     lookup_hit;
    logic [LP*IW-1:0]  lookup_index;
    logic              coalesced;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    wb_addr_queue #(
        .DATA_SIZE(DW), .QUEUE_LENGTH(QL), .REGISTER_SIZE(RW), .LOOKUP_PORTS(LP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .higher_threshold(higher_threshold),
        .push_data(push_data), .push_valid(push_valid), .push_ready(push_ready),
        .pop_data(pop_data), .pop_valid(pop_valid), .pop_ready(pop_ready),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit), .lookup_index(lookup_index), .coalesced(coalesced)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        #1;
    endtask

    task automatic look(input logic [DW-1:0] a0, input logic v0,
                        input logic [DW-1:0] a1, input logic v1);
        lookup_addr  = {a1, a0};
        lookup_valid = {v1, v0};
        #1;
    endtask

    initial begin
        reset_n          = 1'b0;
        higher_threshold = 32'd5;
        push_data        = '0;
        push_valid       = 1'b0;
        pop_ready        = 1'b0;
        lookup_valid     = '0;
        lookup_addr      = '0;

        // Reset state, including a zero-address lookup on the empty queue
        do_reset();
        look(40'h0, 1'b1, 40'h0, 1'b1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_push_ready", push_ready, 1);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_count", count, 0);
        check("rst_hit_zero_empty", lookup_hit, 2'b00);
        check("rst_coalesced", coalesced, 0);

        // Fill with almost_full threshold 5
        for (int i = 0; i < 8; i++) begin
            push(40'h100 + 40'(i));
            check($sformatf("fill_count_%0d", i), count, 64'(i + 1));
            check($sformatf("fill_af_%0d", i), almost_full, (i + 1 >= 5) ? 1 : 0);
        end
        check("fill_full", full, 1);
        check("fill_push_ready", push_ready, 0);
        check("fill_pop_data", pop_data, 40'h100);
        push(40'h1FF);
        check("full_push_ignored", count, 8);

        // Drain and check order, almost_full falls at 4
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_data_%0d", i), pop_data, 40'h100 + 40'(i));
            pop_one();
            check($sformatf("drain_af_%0d", i), almost_full, (7 - i >= 5) ? 1 : 0);
        end
        check("drain_empty", empty, 1);
        check("drain_pop_valid", pop_valid, 0);

        // Concurrent push/pop across pointer wrap at count 3
        push(40'h200);
        push(40'h201);
        push(40'h202);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_data_%0d", i), pop_data, 40'h200 + 40'(i));
            push_valid = 1'b1;
            push_data  = 40'h203 + 40'(i);
            pop_ready  = 1'b1;
            tick();
            check($sformatf("wrap_count_%0d", i), count, 3);
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap_tail_%0d", i), pop_data, 40'h214 + 40'(i));
            tick();
        end
        pop_ready = 1'b0;
        check("wrap_empty", empty, 1);

        // Oldest-match lookup
        do_reset();
        push(40'hA0);
        push(40'hB0);
        push(40'hA0);
`ifdef WB_ADDR_QUEUE_COALESCE_EN
        check("om_count", count, 2);
`else
        check("om_count", count, 3);
`endif
        look(40'hA0, 1'b1, 40'hB0, 1'b1);
        check("om_hit", lookup_hit, 2'b11);
        check("om_idx0", lookup_index[IW-1:0], 0);
        check("om_idx1", lookup_index[2*IW-1:IW], 1);
        look(40'hA0, 1'b0, 40'hC0, 1'b1);
        check("om_strobe_off_miss", lookup_hit, 2'b00);
        // entry being popped still matches
        look(40'hA0, 1'b1, 40'hB0, 1'b1);
        pop_ready = 1'b1;
        #1;
        check("om_popping_hit", lookup_hit[0], 1);
        check("om_popping_idx", lookup_index[IW-1:0], 0);
        tick();
        pop_ready = 1'b0;
        #1;
`ifdef WB_ADDR_QUEUE_COALESCE_EN
        check("om_after_pop_hit", lookup_hit[0], 0);
        check("om_after_pop_idx", lookup_index[IW-1:0], 0);
`else
        check("om_after_pop_hit", lookup_hit[0], 1);
        check("om_after_pop_idx", lookup_index[IW-1:0], 2);
`endif
        check("om_after_pop_idx1", lookup_index[2*IW-1:IW], 1);
        // entry being pushed is not yet visible
        look(40'hC0, 1'b1, 40'hB0, 1'b0);
        push_valid = 1'b1;
        push_data  = 40'hC0;
        #1;
        check("om_pushing_miss", lookup_hit[0], 0);
        tick();
        push_valid = 1'b0;
        #1;
        check("om_pushed_hit", lookup_hit[0], 1);

        // Zero address is legal data
        do_reset();
        push(40'h0);
        look(40'h0, 1'b1, 40'h0, 1'b0);
        check("zero_hit", lookup_hit, 2'b01);
        check("zero_idx", lookup_index[IW-1:0], 0);
        check("zero_pop_valid", pop_valid, 1);

        // Threshold extremes
        higher_threshold = 32'd0;
        #1;
        check("thr0_count1", almost_full, 1);
        higher_threshold = 32'd9;
        #1;
        check("thr9_count1", almost_full, 0);
        higher_threshold = 32'd0;
        do_reset();
        check("thr0_count0", almost_full, 1);
        higher_threshold = 32'd5;

        // Coalescing
        push(40'h40);
        check("co_first_count", count, 1);
        push_valid = 1'b1;
        push_data  = 40'h40;
        #1;
        check("co_push_ready", push_ready, 1);
`ifdef WB_ADDR_QUEUE_COALESCE_EN
        check("co_pulse", coalesced, 1);
`else
        check("co_pulse", coalesced, 0);
`endif
        tick();
        push_valid = 1'b0;
        #1;
        check("co_pulse_gone", coalesced, 0);
`ifdef WB_ADDR_QUEUE_COALESCE_EN
        check("co_count", count, 1);
`else
        check("co_count", count, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
